// File: rtl/circuit4_sched.sv
// Multi-cycle scheduler: one shared add/sub unit and one comparator sequenced by an FSM
// to compute x = (h << dLTe) and z = (g >> dEQe) from operands a, b, c.
module circuit4_sched #(
    parameter int DATAWIDTH = 64,
    parameter int OUTWIDTH  = 32
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic signed [DATAWIDTH-1:0] a,
    input  logic signed [DATAWIDTH-1:0] b,
    input  logic signed [DATAWIDTH-1:0] c,
    output logic                        busy,
    output logic                        done,
    output logic        [OUTWIDTH-1:0]  x,
    output logic        [OUTWIDTH-1:0]  z
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADD_D = 3'd1;
    localparam logic [2:0] S_ADD_E = 3'd2;
    localparam logic [2:0] S_SUB_F = 3'd3;
    localparam logic [2:0] S_CMP   = 3'd4;
    localparam logic [2:0] S_SHIFT = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic        [2:0]           state_q, state_d;
    logic signed [DATAWIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic signed [DATAWIDTH-1:0] d_q, d_d, e_q, e_d, f_q, f_d;
    logic signed [DATAWIDTH-1:0] g_q, g_d, h_q, h_d;
    logic                        lt_q, lt_d, eq_q, eq_d;
    logic        [OUTWIDTH-1:0]  x_q, x_d, z_q, z_d;

    logic signed [DATAWIDTH-1:0] alu_r;
    logic signed [DATAWIDTH-1:0] alu_out;
    logic signed [DATAWIDTH-1:0] g_sel;
    logic                        alu_sub;
    logic                        cmp_lt;
    logic                        cmp_eq;

    always_comb begin
        // Shared adder: subtraction is a + ~b + 1 so only one carry chain exists.
        alu_sub = (state_q == S_SUB_F);
        alu_r   = (state_q == S_ADD_E) ? c_q : b_q;
        alu_out = a_q + (alu_r ^ {DATAWIDTH{alu_sub}}) + {{(DATAWIDTH-1){1'b0}}, alu_sub};
        cmp_lt  = (d_q < e_q);
        cmp_eq  = (d_q == e_q);
        g_sel   = cmp_lt ? d_q : e_q;

        state_d = state_q;
        a_d = a_q;  b_d = b_q;  c_d = c_q;
        d_d = d_q;  e_d = e_q;  f_d = f_q;
        g_d = g_q;  h_d = h_q;
        lt_d = lt_q;  eq_d = eq_q;
        x_d = x_q;  z_d = z_q;

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_d = a;
                        b_d = b;
                        c_d = c;
                        state_d = S_ADD_D;
                    end
                end
                S_ADD_D: begin
                    d_d = alu_out;
                    state_d = S_ADD_E;
                end
                S_ADD_E: begin
                    e_d = alu_out;
                    state_d = S_SUB_F;
                end
                S_SUB_F: begin
                    f_d = alu_out;
                    state_d = S_CMP;
                end
                S_CMP: begin
                    lt_d = cmp_lt;
                    eq_d = cmp_eq;
                    g_d  = g_sel;
                    h_d  = cmp_eq ? g_sel : f_q;
                    state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    x_d = OUTWIDTH'(h_q << lt_q);
                    z_d = OUTWIDTH'($unsigned(g_q) >> eq_q);
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            a_q  <= '0;  b_q <= '0;  c_q <= '0;
            d_q  <= '0;  e_q <= '0;  f_q <= '0;
            g_q  <= '0;  h_q <= '0;
            lt_q <= 1'b0;
            eq_q <= 1'b0;
            x_q  <= '0;
            z_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q  <= a_d;  b_q <= b_d;  c_q <= c_d;
            d_q  <= d_d;  e_q <= e_d;  f_q <= f_d;
            g_q  <= g_d;  h_q <= h_d;
            lt_q <= lt_d;
            eq_q <= eq_d;
            x_q  <= x_d;
            z_q  <= z_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign x    = x_q;
    assign z    = z_q;

endmodule
